// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default latency
// and the address range check used by both the responder and the core's stall logic.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam int unsigned DMEM_LATENCY = 2;

  // True when any byte-address bit above the word-index field is set.
  function automatic logic range_err(input logic [63:0] byte_addr, input int unsigned addr_width);
    return (byte_addr >> (addr_width + 3)) != 64'd0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage with synchronous write and registered read; contents are never reset.
module dmem_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Storage write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one doubleword access at a time, fixed latency,
// stall to the core while busy, and rejection of misaligned/out-of-range/conflicting requests.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LATENCY    = DMEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [63:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  err,
  output logic                  stall
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_state_e           state;
  dmem_state_e           next_state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  is_load;
  logic                  err_q;
  logic                  req;
  logic                  req_err;
  logic                  last;
  logic                  arr_we;
  logic                  arr_re;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign req     = mem_read | mem_write;
  assign req_err = (mem_read & mem_write) | (addr[2:0] != 3'd0) | range_err(addr, ADDR_WIDTH);
  assign last    = (state == BUSY) && (cnt == 4'd0);

  // A rejected access runs the full latency but never touches the array.
  assign arr_we = last & ~is_load & ~err_q & ~reset;
  assign arr_re = last & is_load & ~err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request capture and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      idx     <= '0;
      wdata_q <= '0;
      is_load <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt     <= CNT_LOAD;
            idx     <= addr[ADDR_WIDTH+2:3];
            wdata_q <= wdata;
            is_load <= mem_read;
            err_q   <= req_err;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = BUSY;
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          next_state = DONE;
        end else begin
          next_state = BUSY;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs; stall only looks at the request lines while idle.
  always_comb begin
    done  = (state == DONE);
    err   = done & err_q;
    rdata = '0;
    if (done && !err_q && is_load) begin
      rdata = arr_rdata;
    end else begin
      rdata = '0;
    end
    if (reset) begin
      stall = 1'b0;
    end else begin
      stall = ((state == IDLE) & req) | (state == BUSY);
    end
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .idx  (idx),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: cycle-accurate transaction model checked every cycle,
// plus directed accesses with hand-computed expectations.
module tb_dmem_responder;

  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int LAT = 2;

  localparam logic [63:0] D_A   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D_B   = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] D_OLD = 64'hAAAA_5555_AAAA_5555;
  localparam logic [63:0] D_NEW = 64'h1111_2222_3333_4444;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [63:0]   addr = 64'd0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          done;
  logic          err;
  logic          stall;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction model: an access accepted in cycle S stalls through S+LAT and completes in S+LAT+1.
  logic [63:0] mmem [1024];
  bit          m_pend = 1'b0;
  int          m_start = 0;
  int          m_cyc = 0;
  bit          m_load = 1'b0;
  bit          m_err = 1'b0;
  int          m_idx = 0;
  logic [63:0] m_wdata = 64'd0;

  function automatic bit model_err(input bit rd, input bit wr, input logic [63:0] a);
    logic [63:0] lim;
    lim = 64'd1 << (AW + 3);
    return (rd && wr) || (a % 64'd8 != 64'd0) || (a >= lim);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pend <= 1'b0;
    end else if (!m_pend && (mem_read || mem_write)) begin
      m_pend  <= 1'b1;
      m_start <= m_cyc;
      m_load  <= mem_read;
      m_err   <= model_err(mem_read, mem_write, addr);
      m_idx   <= int'((addr / 64'd8) % 64'd1024);
      m_wdata <= wdata;
    end else if (m_pend && m_cyc == m_start + LAT + 1) begin
      m_pend <= 1'b0;
    end
    if (!reset && m_pend && m_cyc == m_start + LAT && !m_load && !m_err) begin
      mmem[m_idx] <= m_wdata;
    end
    m_cyc <= m_cyc + 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 64'(stall), 64'(!reset && ((m_pend && m_cyc <= m_start + LAT) ||
                                               (!m_pend && (mem_read || mem_write)))));
      check("done", 64'(done), 64'(m_pend && m_cyc == m_start + LAT + 1));
      check("err", 64'(err), 64'(m_pend && m_cyc == m_start + LAT + 1 && m_err));
      check("rdata", rdata, (m_pend && m_cyc == m_start + LAT + 1 && !m_err && m_load) ?
                            mmem[m_idx] : 64'd0);
    end
  end

  // Drives a request and holds it until done; returns at the negedge of the done cycle.
  task automatic access(input bit rd, input bit wr, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rv, output logic ev, output int ns);
    bit ok;
    ok = 1'b0;
    ns = 0;
    rv = 64'd0;
    ev = 1'b0;
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        rv = rdata; ev = err; ok = 1'b1;
        break;
      end
      if (stall) ns++;
      @(posedge clk); #1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL timeout: no done within 20 cycles for addr %h", a);
    end
  endtask

  task automatic run(input string nm, input bit rd, input bit wr, input logic [63:0] a,
                     input logic [63:0] d, input logic exp_err, input logic [63:0] exp_rdata);
    logic [63:0] rv;
    logic        ev;
    int          ns;
    access(rd, wr, a, d, rv, ev, ns);
    check({nm, "_stall_cycles"}, 64'(ns), 64'(LAT + 1));
    check({nm, "_err"}, 64'(ev), 64'(exp_err));
    check({nm, "_rdata"}, rv, exp_rdata);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] rv;
    logic        ev;
    int          ns;
    int          gap;
    int          pulses;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    run("sd_0x40", 1'b0, 1'b1, 64'h40, D_A, 1'b0, 64'd0);
    run("ld_0x40", 1'b1, 1'b0, 64'h40, 64'd0, 1'b0, D_A);
    run("sd_misaligned", 1'b0, 1'b1, 64'h44, D_B, 1'b1, 64'd0);
    run("ld_after_misaligned", 1'b1, 1'b0, 64'h40, 64'd0, 1'b0, D_A);
    run("ld_out_of_range", 1'b1, 1'b0, 64'h2000, 64'd0, 1'b1, 64'd0);
    run("rd_wr_both", 1'b1, 1'b1, 64'h40, D_B, 1'b1, 64'd0);
    run("ld_after_both", 1'b1, 1'b0, 64'h40, 64'd0, 1'b0, D_A);
    run("sd_top_word", 1'b0, 1'b1, 64'h1FF8, D_B, 1'b0, 64'd0);
    run("ld_top_word", 1'b1, 1'b0, 64'h1FF8, 64'd0, 1'b0, D_B);

    // Reset in the middle of a store leaves the old value in place.
    run("sd_old_0x80", 1'b0, 1'b1, 64'h80, D_OLD, 1'b0, 64'd0);
    mem_write = 1'b1; addr = 64'h80; wdata = D_NEW;
    @(posedge clk); #1;
    reset = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    @(negedge clk);
    check("stall_after_reset", 64'(stall), 64'd0);
    for (int i = 0; i < 6; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("no_done_after_reset", 64'(pulses), 64'd0);
    @(posedge clk); #1;
    run("ld_0x80_old", 1'b1, 1'b0, 64'h80, 64'd0, 1'b0, D_OLD);

    // Idle: nothing happens without a request.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stall || done) pulses++;
    end
    check("idle_quiet", 64'(pulses), 64'd0);

    // Back-to-back: a load held across DONE starts a second access.
    @(posedge clk); #1;
    access(1'b1, 1'b0, 64'h40, 64'd0, rv, ev, ns);
    check("b2b_first_rdata", rv, D_A);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      gap++;
      if (done) break;
    end
    check("b2b_gap", 64'(gap), 64'(LAT + 2));
    check("b2b_second_rdata", rdata, D_A);
    @(posedge clk); #1;
    mem_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the sequential RISC-V core: the far end of the `MemRead`/`MemWrite` request issued by the main control decoder for `ld`/`sd`. It accepts one doubleword access at a time, models a fixed multi-cycle memory latency, and holds `stall` high so the core freezes its PC and register writeback until the access completes. It also reports misaligned and out-of-range accesses instead of performing them.

## Interface
- `ADDR_WIDTH`, default 10: word-index bits; storage is 2^ADDR_WIDTH doublewords.
- `DATA_WIDTH`, default 64: doubleword width.
- `LATENCY`, default 2: BUSY cycles per access; legal range 1..15.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load request from control (`MemRead`).
- `mem_write`  in  1  store request from control (`MemWrite`).
- `addr`  in  64  byte address from the ALU result.
- `wdata`  in  DATA_WIDTH  store data (rs2).
- `rdata`  out  DATA_WIDTH  load data; valid only while `done`=1.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualified by `done`: access was rejected.
- `stall`  out  1  core must hold PC and suppress writeback.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Request: `req = mem_read | mem_write`, sampled only in IDLE.
- IDLE with `req`=1: latch `addr`, `wdata`, op type; load the 4-bit counter with LATENCY-1; go to BUSY.
- IDLE with `req`=0: stay in IDLE.
- BUSY: decrement the counter each cycle. When counter==0, go to DONE.
- BUSY→DONE edge, load: register `rdata` from the array at index `addr[ADDR_WIDTH+2:3]`.
- BUSY→DONE edge, store: write the latched `wdata` to that index.
- DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- Requests in BUSY or DONE are ignored. The core holds them stable because `stall` is high.
- `stall = (IDLE & req) | BUSY`. It is 0 in DONE, so the core advances on that edge.
- Error cases:
  - `mem_read` and `mem_write` both 1.
  - `addr[2:0]` != 0 (misaligned).
  - Any of `addr[63:ADDR_WIDTH+3]` nonzero (out of range).
- On an error the access still follows the full IDLE→BUSY→DONE sequence and latency. In DONE, `err`=1 and `rdata`=0, and the array is not written.
- Reset values: state=IDLE, counter=0, `rdata`=0, `done`=0, `err`=0. `stall` is forced to 0 while `reset`=1.
- Reset mid-access: the pending store is discarded and the array is unchanged. Array contents are never reset.

## Timing
- Request first high in cycle N (state IDLE): `stall`=1 in cycles N through N+LATENCY.
- `done`, `rdata`, and `err` are valid in cycle N+LATENCY+1, with `stall`=0 in that cycle.
- A store becomes visible to a load accepted in cycle N+LATENCY+2 or later.
- Back-to-back accesses: a request present in the cycle after DONE is a new access. Minimum spacing is LATENCY+2 cycles.
- No combinational path from `addr`/`wdata` to `rdata`. `stall` is combinational from `mem_read`/`mem_write` in IDLE only.

## Structure
- Shared package `dmem_pkg`: FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and a default `LATENCY` constant, shared with the core's stall logic.
- Sub-module `dmem_array`: 2^ADDR_WIDTH × DATA_WIDTH storage with synchronous write enable and registered read, no reset.
- The FSM, counter, and error checks live in `dmem_responder`.

## Test plan
- Store then load, LATENCY=2: `sd` writes 0x0123_4567_89AB_CDEF to addr 0x40 → `stall` high for 3 cycles, `done` with `err`=0. A following `ld` from 0x40 returns the same value in cycle N+3.
- Misaligned store: `mem_write` with addr 0x44 → `done`=1, `err`=1. A later load from 0x40 still returns its previous value.
- Out-of-range load: addr 0x2000 with ADDR_WIDTH=10 → `done`=1, `err`=1, `rdata`=0.
- Both `mem_read` and `mem_write` high → `err`=1 and no array write.
- Reset mid-access: assert `reset` in BUSY of an `sd` to 0x80 → next cycle IDLE, `stall`=0, `done` never pulses. A load from 0x80 returns the old data.
- Idle and back-to-back: no request → `stall`=0 and `done`=0 for 10 cycles. Then a request held across DONE starts a second access with correct latency.
